// File: rtl/alu_ctrl_pkg.sv
// Package for the registered ALU-control pipeline stage.
// Holds the ALU operation code enum, the funct and ALUOp encodings from the
// MIPS instruction set, and the multi-cycle sequencer state enum.
package alu_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOR = 4'd5,
        OP_SLT = 4'd6,
        OP_SLL = 4'd7,
        OP_SRL = 4'd8,
        OP_MUL = 4'd9,
        OP_DIV = 4'd10
    } alu_op_e;

    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SRL = 6'h02;
    localparam logic [5:0] FUNCT_JR  = 6'h08;
    localparam logic [5:0] FUNCT_MUL = 6'h18;
    localparam logic [5:0] FUNCT_DIV = 6'h1A;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_XOR = 6'h26;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam logic [1:0] ALUOP_RTYPE = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_OR    = 2'b10;
    localparam logic [1:0] ALUOP_ADD   = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational ALU-control decode.
// Ports:
//   alu_op  in   ALUOp from main control
//   funct   in   R-type funct field
//   ctrl    out  ALU operation code
//   jr      out  instruction is JR
//   illegal out  R-type funct not recognised (decodes as ADD)
//   md      out  instruction is MUL or DIV (multi-cycle)
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 2,
    parameter int FUNCT_W = 6,
    parameter int CTRL_W  = 4
) (
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic [CTRL_W-1:0]  ctrl,
    output logic               jr,
    output logic               illegal,
    output logic               md
);

    alu_op_e op;

    always_comb begin
        op      = OP_ADD;
        jr      = 1'b0;
        illegal = 1'b0;
        md      = 1'b0;
        case (alu_op)
            ALUOP_ADD: op = OP_ADD;
            ALUOP_SUB: op = OP_SUB;
            ALUOP_OR:  op = OP_OR;
            default: begin
                case (funct)
                    FUNCT_ADD: op = OP_ADD;
                    FUNCT_SUB: op = OP_SUB;
                    FUNCT_AND: op = OP_AND;
                    FUNCT_OR:  op = OP_OR;
                    FUNCT_XOR: op = OP_XOR;
                    FUNCT_NOR: op = OP_NOR;
                    FUNCT_SLT: op = OP_SLT;
                    FUNCT_SLL: op = OP_SLL;
                    FUNCT_SRL: op = OP_SRL;
                    FUNCT_MUL: begin
                        op = OP_MUL;
                        md = 1'b1;
                    end
                    FUNCT_DIV: begin
                        op = OP_DIV;
                        md = 1'b1;
                    end
                    // JR still drives the ALU as ADD so the datapath stays benign.
                    FUNCT_JR:  jr = 1'b1;
                    default:   illegal = 1'b1;
                endcase
            end
        endcase
    end

    assign ctrl = CTRL_W'(op);

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU-control decode at the ID->EX boundary.
// Decodes {ALUOp, funct} into the EX register and sequences multi-cycle
// MUL/DIV: while BUSY the ID stage is stalled (id_ready=0, md_busy=1) and the
// EX register is frozen for MD_LAT cycles; md_done pulses in the last one.
// Handshake: an instruction is accepted on a rising edge where id_valid and
// id_ready are both 1; ex_flush kills the accept and clears the live flags.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   id_valid            ID holds a valid instruction
//   id_alu_op, id_funct decode inputs
//   ex_hold, ex_flush   downstream stall / redirect kill
//   id_ready            ID instruction accepted this cycle when id_valid=1
//   ex_valid, ex_alu_ctrl, ex_jr, ex_illegal, ex_md_op  EX register
//   md_busy, md_done    multi-cycle stall request / completion pulse
module alu_ctrl_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 2,
    parameter int FUNCT_W = 6,
    parameter int CTRL_W  = 4,
    parameter int MD_LAT  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic [FUNCT_W-1:0] id_funct,
    input  logic               ex_hold,
    input  logic               ex_flush,
    output logic               id_ready,
    output logic               ex_valid,
    output logic [CTRL_W-1:0]  ex_alu_ctrl,
    output logic               ex_jr,
    output logic               ex_illegal,
    output logic               ex_md_op,
    output logic               md_busy,
    output logic               md_done
);

    localparam int CNT_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ex_valid_q, ex_valid_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic              ex_jr_q, ex_jr_d;
    logic              ex_ill_q, ex_ill_d;
    logic              ex_md_q, ex_md_d;

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_jr, dec_ill, dec_md;
    logic              ready_raw;

    alu_ctrl_decode #(
        .ALUOP_W (ALUOP_W),
        .FUNCT_W (FUNCT_W),
        .CTRL_W  (CTRL_W)
    ) u_decode (
        .alu_op  (id_alu_op),
        .funct   (id_funct),
        .ctrl    (dec_ctrl),
        .jr      (dec_jr),
        .illegal (dec_ill),
        .md      (dec_md)
    );

    assign ready_raw = (state_q == IDLE) && !ex_hold;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ex_valid_d = ex_valid_q;
        ex_ctrl_d  = ex_ctrl_q;
        ex_jr_d    = ex_jr_q;
        ex_ill_d   = ex_ill_q;
        ex_md_d    = ex_md_q;
        if (ex_flush) begin
            // Redirect beats everything: kills any accept, hold or MUL/DIV.
            ex_valid_d = 1'b0;
            ex_jr_d    = 1'b0;
            ex_ill_d   = 1'b0;
            ex_md_d    = 1'b0;
            state_d    = IDLE;
            cnt_d      = '0;
        end else if (state_q == BUSY) begin
            // EX frozen; the count runs regardless of ex_hold.
            if (cnt_q == '0) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (!ex_hold) begin
            if (id_valid) begin
                ex_valid_d = 1'b1;
                ex_ctrl_d  = dec_ctrl;
                ex_jr_d    = dec_jr;
                ex_ill_d   = dec_ill;
                ex_md_d    = dec_md;
                if (dec_md) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(MD_LAT - 1);
                end
            end else begin
                ex_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_jr_q    <= 1'b0;
            ex_ill_q   <= 1'b0;
            ex_md_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_jr_q    <= ex_jr_d;
            ex_ill_q   <= ex_ill_d;
            ex_md_q    <= ex_md_d;
        end
    end

    // id_ready is forced low while reset is asserted so every output reads 0.
    assign id_ready    = rst_n && ready_raw;
    assign ex_valid    = ex_valid_q;
    assign ex_alu_ctrl = ex_ctrl_q;
    assign ex_jr       = ex_jr_q;
    assign ex_illegal  = ex_ill_q;
    assign ex_md_op    = ex_md_q;
    assign md_busy     = (state_q == BUSY);
    // A flush in the final BUSY cycle aborts the op, so no completion pulse.
    assign md_done     = (state_q == BUSY) && (cnt_q == '0) && !ex_flush;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
module tb_alu_ctrl_pipe;

    localparam int MD_LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [1:0] id_alu_op = 2'b00;
    logic [5:0] id_funct = 6'h00;
    logic       ex_hold = 1'b0;
    logic       ex_flush = 1'b0;
    logic       id_ready, ex_valid, ex_jr, ex_illegal, ex_md_op, md_busy, md_done;
    logic [3:0] ex_alu_ctrl;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state: EX contents plus number of BUSY cycles left.
    logic       m_valid, m_jr, m_ill, m_md;
    logic [3:0] m_ctrl;
    int         m_left;

    logic [10:0] obs;
    logic [10:0] exp_v;
    logic [10:0] mask_v;

    alu_ctrl_pipe #(.MD_LAT(MD_LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_alu_op   (id_alu_op),
        .id_funct    (id_funct),
        .ex_hold     (ex_hold),
        .ex_flush    (ex_flush),
        .id_ready    (id_ready),
        .ex_valid    (ex_valid),
        .ex_alu_ctrl (ex_alu_ctrl),
        .ex_jr       (ex_jr),
        .ex_illegal  (ex_illegal),
        .ex_md_op    (ex_md_op),
        .md_busy     (md_busy),
        .md_done     (md_done)
    );

    always #5 clk = ~clk;

    assign obs = {id_ready, ex_valid, ex_alu_ctrl, ex_jr, ex_illegal, ex_md_op, md_busy, md_done};

    // {ctrl, jr, illegal, md} straight from the instruction-set table.
    function automatic logic [6:0] ref_decode(input logic [1:0] aluop, input logic [5:0] f);
        if (aluop == 2'b11) return {4'd0, 3'b000};
        if (aluop == 2'b01) return {4'd1, 3'b000};
        if (aluop == 2'b10) return {4'd3, 3'b000};
        case (f)
            6'h20: return {4'd0, 3'b000};
            6'h22: return {4'd1, 3'b000};
            6'h24: return {4'd2, 3'b000};
            6'h25: return {4'd3, 3'b000};
            6'h26: return {4'd4, 3'b000};
            6'h27: return {4'd5, 3'b000};
            6'h2A: return {4'd6, 3'b000};
            6'h00: return {4'd7, 3'b000};
            6'h02: return {4'd8, 3'b000};
            6'h18: return {4'd9, 3'b001};
            6'h1A: return {4'd10, 3'b001};
            6'h08: return {4'd0, 3'b100};
            default: return {4'd0, 3'b010};
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_ctrl = 4'd0; m_jr = 1'b0; m_ill = 1'b0; m_md = 1'b0;
        m_left = 0;
    endtask

    // Expected outputs for the current cycle, given the current inputs.
    task automatic model_expect();
        exp_v = {rst_n && (m_left == 0) && !ex_hold, m_valid, m_ctrl, m_jr, m_ill, m_md,
                 m_left > 0, (m_left == 1) && !ex_flush};
        mask_v = m_valid ? 11'h7FF : 11'b11_0000_000_11;
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic model_step();
        logic [6:0] d;
        d = ref_decode(id_alu_op, id_funct);
        if (ex_flush) begin
            m_valid = 1'b0; m_jr = 1'b0; m_ill = 1'b0; m_md = 1'b0;
            m_left = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
        end else if (!ex_hold) begin
            if (id_valid) begin
                m_valid = 1'b1;
                {m_ctrl, m_jr, m_ill, m_md} = d;
                if (d[0]) m_left = MD_LAT;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] a, input logic [5:0] f,
                         input logic h, input logic fl);
        id_valid = v; id_alu_op = a; id_funct = f; ex_hold = h; ex_flush = fl;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if (obs !== 11'd0) begin
            n_fail++; $display("FAIL reset_hold: got %b expected %b", obs, 11'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (obs !== 11'b10_0000_000_00) begin
            n_fail++; $display("FAIL reset_release: got %b expected %b", obs, 11'b10_0000_000_00);
        end
        @(posedge clk); #1;
        // Enter BUSY with a MUL, then reset mid-cycle while busy.
        drive(1'b1, 2'b00, 6'h18, 1'b0, 1'b0);
        tick();
        drive(1'b0, 2'b00, 6'h00, 1'b0, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs !== 11'd0) begin
            n_fail++; $display("FAIL reset_async_busy: got %b expected %b", obs, 11'd0);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        model_expect();
        n_checks++;
        if (obs !== 11'b10_0000_000_00) begin
            n_fail++; $display("FAIL reset_busy_release: got %b expected %b", obs, 11'b10_0000_000_00);
        end
        tick();
    endtask

    task automatic test_decode_sweep();
        logic [5:0] fl [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h20, 6'h20, 6'h20};
        logic [1:0] al [12] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b10};
        logic [3:0] ex [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd0, 4'd1, 4'd3};
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, al[i], fl[i], 1'b0, 1'b0);
            tick();
            drive(1'b0, 2'b00, 6'h00, 1'b0, 1'b0);
            @(negedge clk);
            n_checks++;
            if ({ex_valid, ex_alu_ctrl, ex_jr, ex_illegal, ex_md_op} !== {1'b1, ex[i], 3'b000}) begin
                n_fail++;
                $display("FAIL decode_%0d: got v=%b ctrl=%0d flags=%b expected v=1 ctrl=%0d flags=000",
                         i, ex_valid, ex_alu_ctrl, {ex_jr, ex_illegal, ex_md_op}, ex[i]);
            end
        end
        tick();
    endtask

    task automatic test_jr_illegal();
        drive(1'b1, 2'b00, 6'h08, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'b00, 6'h3F, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({ex_valid, ex_alu_ctrl, ex_jr, ex_illegal, ex_md_op} !== 8'b1_0000_100) begin
            n_fail++; $display("FAIL jr: got %b expected %b",
                               {ex_valid, ex_alu_ctrl, ex_jr, ex_illegal, ex_md_op}, 8'b1_0000_100);
        end
        tick();
        drive(1'b0, 2'b00, 6'h00, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({ex_valid, ex_alu_ctrl, ex_jr, ex_illegal, ex_md_op} !== 8'b1_0000_010) begin
            n_fail++; $display("FAIL illegal: got %b expected %b",
                               {ex_valid, ex_alu_ctrl, ex_jr, ex_illegal, ex_md_op}, 8'b1_0000_010);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (ex_valid !== 1'b0) begin
            n_fail++; $display("FAIL bubble: got ex_valid=%b expected 0", ex_valid);
        end
        tick();
    endtask

    // MUL accepted in cycle 0; busy cycles 1..4 (ex_hold raised in cycle 2 must not
    // stretch it); md_done in cycle 4; DIV offered throughout, accepted in cycle 5.
    task automatic test_back_to_back();
        drive(1'b1, 2'b00, 6'h18, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (id_ready !== 1'b1) begin
            n_fail++; $display("FAIL mul_accept: got id_ready=%b expected 1", id_ready);
        end
        tick();
        for (int c = 1; c <= 5; c++) begin
            drive(1'b1, 2'b00, 6'h1A, c == 2, 1'b0);
            @(negedge clk);
            n_checks++;
            if ({id_ready, md_busy, md_done, ex_alu_ctrl, ex_md_op} !==
                {c == 5, c <= 4, c == 4, 4'd9, 1'b1}) begin
                n_fail++;
                $display("FAIL mul_cycle_%0d: got rdy=%b busy=%b done=%b ctrl=%0d md=%b expected rdy=%b busy=%b done=%b ctrl=9 md=1",
                         c, id_ready, md_busy, md_done, ex_alu_ctrl, ex_md_op, c == 5, c <= 4, c == 4);
            end
            tick();
        end
        drive(1'b0, 2'b00, 6'h00, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({ex_alu_ctrl, md_busy, id_ready} !== {4'd10, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL div_after_mul: got ctrl=%0d busy=%b rdy=%b expected ctrl=10 busy=1 rdy=0",
                               ex_alu_ctrl, md_busy, id_ready);
        end
        for (int c = 0; c < MD_LAT; c++) tick();
    endtask

    task automatic test_flush_busy();
        logic seen_done;
        seen_done = 1'b0;
        drive(1'b1, 2'b00, 6'h1A, 1'b0, 1'b0);
        tick();
        drive(1'b0, 2'b00, 6'h00, 1'b0, 1'b0);
        @(negedge clk);
        seen_done = seen_done | md_done;
        tick();
        drive(1'b0, 2'b00, 6'h00, 1'b0, 1'b1);
        @(negedge clk);
        seen_done = seen_done | md_done;
        tick();
        drive(1'b0, 2'b00, 6'h00, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({id_ready, ex_valid, md_busy, ex_md_op} !== 4'b1000) begin
            n_fail++; $display("FAIL flush_busy_idle: got rdy/v/busy/md=%b expected 1000",
                               {id_ready, ex_valid, md_busy, ex_md_op});
        end
        for (int c = 0; c < MD_LAT + 2; c++) begin
            @(negedge clk);
            seen_done = seen_done | md_done;
            tick();
        end
        n_checks++;
        if (seen_done !== 1'b0) begin
            n_fail++; $display("FAIL flush_busy_no_done: got md_done seen=%b expected 0", seen_done);
        end
    endtask

    task automatic test_hold_flush();
        drive(1'b1, 2'b00, 6'h08, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'b00, 6'h22, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++;
        if (id_ready !== 1'b0) begin
            n_fail++; $display("FAIL hold_ready: got id_ready=%b expected 0", id_ready);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({ex_valid, ex_alu_ctrl, ex_jr} !== {1'b1, 4'd0, 1'b1}) begin
            n_fail++; $display("FAIL hold_keep: got v=%b ctrl=%0d jr=%b expected v=1 ctrl=0 jr=1",
                               ex_valid, ex_alu_ctrl, ex_jr);
        end
        drive(1'b1, 2'b00, 6'h22, 1'b1, 1'b1);
        tick();
        drive(1'b0, 2'b00, 6'h00, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({ex_valid, ex_jr, ex_illegal, ex_md_op} !== 4'b0000) begin
            n_fail++; $display("FAIL hold_flush: got v/jr/ill/md=%b expected 0000",
                               {ex_valid, ex_jr, ex_illegal, ex_md_op});
        end
        tick();
    endtask

    task automatic test_random();
        logic [5:0] known [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h18, 6'h1A, 6'h08};
        logic [5:0] f;
        for (int i = 0; i < 400; i++) begin
            f = ($urandom_range(0, 3) != 0) ? known[$urandom_range(0, 11)] : 6'($urandom);
            drive($urandom_range(0, 3) != 0, 2'($urandom), f,
                  $urandom_range(0, 6) == 0, $urandom_range(0, 11) == 0);
            @(negedge clk);
            model_expect();
            n_checks++;
            if ((obs & mask_v) !== (exp_v & mask_v)) begin
                n_fail++; $display("FAIL random_%0d: got %b expected %b (mask %b)",
                                   i, obs, exp_v, mask_v);
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_decode_sweep();
        test_jr_illegal();
        test_back_to_back();
        test_flush_busy();
        test_hold_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
